// File: rtl/user_time_editor_if.sv
// Button, RTC-snapshot and edited-value bundle between the user time editor and its neighbours.
// fsm_state mirrors the editor FSM (0 IDLE, 1 LOAD, 2 EDIT, 3 COMMIT) for observation.
interface user_time_editor_if;
  logic       btn_escr, btn_modo, btn_izq, btn_der, btn_arriba, btn_abajo;
  logic [7:0] seg_RTC, min_RTC, hora_RTC, dia_RTC, mes_RTC, ano_RTC;
  logic [7:0] seg_T_RTC, min_T_RTC, hora_T_RTC;
  logic       En_Escr, En_clock, wr_pulse;
  logic [7:0] seg_usu, min_usu, hora_usu, dia_usu, mes_usu, ano_usu;
  logic [7:0] seg_T_usu, min_T_usu, hora_T_usu;
  logic [2:0] campo;
  logic [1:0] fsm_state;

  modport master (
    output btn_escr, btn_modo, btn_izq, btn_der, btn_arriba, btn_abajo,
    output seg_RTC, min_RTC, hora_RTC, dia_RTC, mes_RTC, ano_RTC,
    output seg_T_RTC, min_T_RTC, hora_T_RTC,
    input  En_Escr, En_clock, wr_pulse, campo, fsm_state,
    input  seg_usu, min_usu, hora_usu, dia_usu, mes_usu, ano_usu,
    input  seg_T_usu, min_T_usu, hora_T_usu
  );

  modport slave (
    input  btn_escr, btn_modo, btn_izq, btn_der, btn_arriba, btn_abajo,
    input  seg_RTC, min_RTC, hora_RTC, dia_RTC, mes_RTC, ano_RTC,
    input  seg_T_RTC, min_T_RTC, hora_T_RTC,
    output En_Escr, En_clock, wr_pulse, campo, fsm_state,
    output seg_usu, min_usu, hora_usu, dia_usu, mes_usu, ano_usu,
    output seg_T_usu, min_T_usu, hora_T_usu
  );
endinterface

// File: rtl/user_time_editor.sv
// Button-driven editor for RTC clock/date and timer values in BCD; loads a snapshot,
// lets the user walk fields and step them, then strobes a commit to the RTC writer.
module user_time_editor (
  input  logic                 clk,
  input  logic                 reset,
  user_time_editor_if.slave    bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EDIT = 2'd2, COMMIT = 2'd3} state_t;

  state_t     state, next_state;
  logic [5:0] btn_now, btn_prev, ev;
  logic       ev_escr, ev_modo, ev_izq, ev_der, ev_arriba, ev_abajo;
  logic       en_clock;
  logic [2:0] campo, campo_max;
  logic [3:0] sel;
  logic [7:0] sel_val, sel_lo, sel_hi;
  // Fields 0..5: seg, min, hora, dia, mes, ano; 6..8: seg_T, min_T, hora_T.
  logic [7:0] usu [0:8];
  logic [7:0] rtc [0:8];

  function automatic logic [7:0] field_hi(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd6, 4'd7: return 8'h59;
      4'd2, 4'd8:             return 8'h23;
      4'd3:                   return 8'h31;
      4'd4:                   return 8'h12;
      default:                return 8'h99;
    endcase
  endfunction

  // Out-of-range values snap to a bound so the field can never leave its BCD range.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v >= hi || v < lo)    return lo;
    else if (v[3:0] >= 4'h9)  return {v[7:4] + 4'd1, 4'h0};
    else                      return v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v <= lo || v > hi)    return hi;
    else if (v[3:0] == 4'h0)  return {v[7:4] - 4'd1, 4'h9};
    else                      return v - 8'd1;
  endfunction

  assign btn_now = {bus.btn_escr, bus.btn_modo, bus.btn_izq,
                    bus.btn_der, bus.btn_arriba, bus.btn_abajo};
  assign ev = btn_now & ~btn_prev;
  assign {ev_escr, ev_modo, ev_izq, ev_der, ev_arriba, ev_abajo} = ev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) btn_prev <= 6'b0;
    else        btn_prev <= btn_now;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ev_escr) next_state = LOAD;
      LOAD:    next_state = EDIT;
      EDIT:    if (ev_escr) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign rtc[0] = bus.seg_RTC;
  assign rtc[1] = bus.min_RTC;
  assign rtc[2] = bus.hora_RTC;
  assign rtc[3] = bus.dia_RTC;
  assign rtc[4] = bus.mes_RTC;
  assign rtc[5] = bus.ano_RTC;
  assign rtc[6] = bus.seg_T_RTC;
  assign rtc[7] = bus.min_T_RTC;
  assign rtc[8] = bus.hora_T_RTC;

  assign campo_max = en_clock ? 3'd5 : 3'd2;
  assign sel       = en_clock ? {1'b0, campo} : {1'b0, campo} + 4'd6;
  assign sel_val   = usu[sel];
  assign sel_hi    = field_hi(sel);
  assign sel_lo    = (sel == 4'd3 || sel == 4'd4) ? 8'h01 : 8'h00;

  // Only the highest-priority event class acts; opposing pairs cancel within a class.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_clock <= 1'b1;
      campo    <= 3'd0;
      for (int i = 0; i < 9; i++) usu[i] <= 8'h00;
      usu[3] <= 8'h01;
      usu[4] <= 8'h01;
    end else begin
      case (state)
        LOAD: begin
          for (int i = 0; i < 9; i++) usu[i] <= rtc[i];
          campo <= 3'd0;
        end
        EDIT: begin
          if (ev_escr) begin
            campo <= campo;
          end else if (ev_modo) begin
            en_clock <= ~en_clock;
            campo    <= 3'd0;
          end else if (ev_izq || ev_der) begin
            if (ev_izq && !ev_der)
              campo <= (campo == 3'd0) ? campo_max : campo - 3'd1;
            else if (ev_der && !ev_izq)
              campo <= (campo >= campo_max) ? 3'd0 : campo + 3'd1;
          end else if (ev_arriba ^ ev_abajo) begin
            usu[sel] <= ev_arriba ? bcd_inc(sel_val, sel_lo, sel_hi)
                                  : bcd_dec(sel_val, sel_lo, sel_hi);
          end
        end
        default: campo <= campo;
      endcase
    end
  end

  assign bus.En_Escr    = (state != IDLE);
  assign bus.wr_pulse   = (state == COMMIT);
  assign bus.En_clock   = en_clock;
  assign bus.campo      = campo;
  assign bus.fsm_state  = state;
  assign bus.seg_usu    = usu[0];
  assign bus.min_usu    = usu[1];
  assign bus.hora_usu   = usu[2];
  assign bus.dia_usu    = usu[3];
  assign bus.mes_usu    = usu[4];
  assign bus.ano_usu    = usu[5];
  assign bus.seg_T_usu  = usu[6];
  assign bus.min_T_usu  = usu[7];
  assign bus.hora_T_usu = usu[8];

endmodule

// File: tb/tb_user_time_editor.sv
// Directed bench for user_time_editor: load, field walking, BCD wrap, priority, commit
// strobe and asynchronous reset, all against hand-computed values.
module tb_user_time_editor;

  localparam logic [5:0] B_ESCR = 6'b100000;
  localparam logic [5:0] B_MODO = 6'b010000;
  localparam logic [5:0] B_IZQ  = 6'b001000;
  localparam logic [5:0] B_DER  = 6'b000100;
  localparam logic [5:0] B_ARR  = 6'b000010;
  localparam logic [5:0] B_ABA  = 6'b000001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] exp_q [$];

  user_time_editor_if bus ();

  user_time_editor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic set_btns(input logic [5:0] m);
    {bus.btn_escr, bus.btn_modo, bus.btn_izq, bus.btn_der, bus.btn_arriba, bus.btn_abajo} = m;
  endtask

  // Called on a negedge; event lands on the next posedge, returns two negedges later.
  task automatic press(input logic [5:0] m);
    set_btns(m);
    @(negedge clk);
    set_btns(6'b0);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    set_btns(6'b0);
    bus.seg_RTC = 8'h56; bus.min_RTC = 8'h34; bus.hora_RTC = 8'h12;
    bus.dia_RTC = 8'h15; bus.mes_RTC = 8'h08; bus.ano_RTC  = 8'h16;
    bus.seg_T_RTC = 8'h45; bus.min_T_RTC = 8'h30; bus.hora_T_RTC = 8'h23;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_en_escr", {7'b0, bus.En_Escr}, 8'h00);
    check("rst_en_clock", {7'b0, bus.En_clock}, 8'h01);
    check("rst_campo", {5'b0, bus.campo}, 8'h00);
    check("rst_wr", {7'b0, bus.wr_pulse}, 8'h00);
    check("rst_seg", bus.seg_usu, 8'h00);
    check("rst_dia", bus.dia_usu, 8'h01);
    check("rst_mes", bus.mes_usu, 8'h01);
    reset = 1'b1;
    @(negedge clk);

    // load snapshot
    press(B_ESCR);
    check("load_seg", bus.seg_usu, 8'h56);
    check("load_hora", bus.hora_usu, 8'h12);
    check("load_ano", bus.ano_usu, 8'h16);
    check("load_dia", bus.dia_usu, 8'h15);
    check("load_en_escr", {7'b0, bus.En_Escr}, 8'h01);
    check("load_campo", {5'b0, bus.campo}, 8'h00);
    check("load_state", {6'b0, bus.fsm_state}, 8'h02);

    // clock-mode wraps
    repeat (3) press(B_ARR);
    check("seg_59", bus.seg_usu, 8'h59);
    press(B_ARR);
    check("seg_wrap_00", bus.seg_usu, 8'h00);
    repeat (3) press(B_DER);
    check("campo_3", {5'b0, bus.campo}, 8'h03);
    for (int i = 0; i < 14; i++) press(B_ABA);
    check("dia_01", bus.dia_usu, 8'h01);
    press(B_ABA);
    check("dia_wrap_31", bus.dia_usu, 8'h31);
    press(B_DER);
    repeat (4) press(B_ARR);
    check("mes_12", bus.mes_usu, 8'h12);
    press(B_ARR);
    check("mes_wrap_01", bus.mes_usu, 8'h01);
    press(B_DER);
    press(B_DER);
    check("campo_wrap_der", {5'b0, bus.campo}, 8'h00);
    press(B_IZQ | B_ARR);
    check("campo_wrap_izq", {5'b0, bus.campo}, 8'h05);
    check("izq_over_arriba", bus.ano_usu, 8'h16);
    press(B_DER);

    // timer mode
    press(B_MODO);
    check("modo_en_clock", {7'b0, bus.En_clock}, 8'h00);
    check("modo_campo", {5'b0, bus.campo}, 8'h00);
    press(B_IZQ);
    check("timer_campo_2", {5'b0, bus.campo}, 8'h02);
    press(B_ARR);
    check("hora_t_wrap", bus.hora_T_usu, 8'h00);
    check("hora_untouched", bus.hora_usu, 8'h12);
    press(B_ARR | B_ABA);
    check("arr_aba_noop", bus.hora_T_usu, 8'h00);
    press(B_IZQ | B_DER);
    check("izq_der_noop", {5'b0, bus.campo}, 8'h02);

    // modo outranks der and arriba
    press(B_MODO | B_DER | B_ARR);
    check("prio_en_clock", {7'b0, bus.En_clock}, 8'h01);
    check("prio_campo", {5'b0, bus.campo}, 8'h00);
    check("prio_seg", bus.seg_usu, 8'h00);

    // BCD carry across nibbles on min
    press(B_DER);
    for (int i = 0; i < 25; i++) press(B_ABA);
    check("min_09", bus.min_usu, 8'h09);
    press(B_ARR);
    check("min_carry_10", bus.min_usu, 8'h10);
    press(B_ABA);
    check("min_borrow_09", bus.min_usu, 8'h09);
    press(B_ARR);

    // commit: escr beats arriba
    exp_q = {8'h00, 8'h10, 8'h12, 8'h31, 8'h01, 8'h16, 8'h45, 8'h30, 8'h00};
    set_btns(B_ESCR | B_ARR);
    @(negedge clk);
    set_btns(6'b0);
    check("commit_wr_hi", {7'b0, bus.wr_pulse}, 8'h01);
    check("commit_en_escr", {7'b0, bus.En_Escr}, 8'h01);
    check("commit_seg", bus.seg_usu, exp_q.pop_front());
    check("commit_min", bus.min_usu, exp_q.pop_front());
    check("commit_hora", bus.hora_usu, exp_q.pop_front());
    check("commit_dia", bus.dia_usu, exp_q.pop_front());
    check("commit_mes", bus.mes_usu, exp_q.pop_front());
    check("commit_ano", bus.ano_usu, exp_q.pop_front());
    check("commit_seg_t", bus.seg_T_usu, exp_q.pop_front());
    check("commit_min_t", bus.min_T_usu, exp_q.pop_front());
    check("commit_hora_t", bus.hora_T_usu, exp_q.pop_front());
    @(negedge clk);
    check("commit_wr_lo", {7'b0, bus.wr_pulse}, 8'h00);
    check("idle_en_escr", {7'b0, bus.En_Escr}, 8'h00);

    // idle ignores edits
    press(B_ARR);
    check("idle_hold_seg", bus.seg_usu, 8'h00);
    press(B_MODO);
    check("idle_hold_en_clock", {7'b0, bus.En_clock}, 8'h01);

    // reload, edit, then async reset mid-edit with escr held
    press(B_ESCR);
    check("reload_seg", bus.seg_usu, 8'h56);
    press(B_ARR);
    check("reload_seg_57", bus.seg_usu, 8'h57);
    set_btns(B_ESCR);
    #2 reset = 1'b0;
    #1;
    check("async_seg", bus.seg_usu, 8'h00);
    check("async_min", bus.min_usu, 8'h00);
    check("async_dia", bus.dia_usu, 8'h01);
    check("async_mes", bus.mes_usu, 8'h01);
    check("async_en_escr", {7'b0, bus.En_Escr}, 8'h00);
    check("async_wr", {7'b0, bus.wr_pulse}, 8'h00);
    check("async_campo", {5'b0, bus.campo}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("held_btn_load", {6'b0, bus.fsm_state}, 8'h01);
    set_btns(6'b0);
    @(negedge clk);
    check("held_btn_seg", bus.seg_usu, 8'h56);
    check("held_btn_edit", {6'b0, bus.fsm_state}, 8'h02);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
